// File: rtl/rand_range_sampler_if.sv
// rtl/rand_range_sampler_if.sv - request and output stream bundle for rand_range_sampler
interface rand_range_sampler_if #(
  parameter int CNT_W = 4
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_mode_i;
  logic [CNT_W-1:0] req_count_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [7:0]       out_data_o;
  logic             out_last_o;

  modport slave (
    input  req_valid_i, req_mode_i, req_count_i, out_ready_i,
    output req_ready_o, out_valid_o, out_data_o, out_last_o
  );

  modport master (
    output req_valid_i, req_mode_i, req_count_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/rand_range_sampler.sv
// rtl/rand_range_sampler.sv - maps raw LFSR samples into bounded values; optional RANGE_REJECT_LIMIT_EN
module rand_range_sampler #(
  parameter int S_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [S_WIDTH-1:0] rnd_i,
  input  logic               rnd_valid_i,
  output logic               lfsr_start_o,
  output logic               busy_o,
  rand_range_sampler_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = CNT_W + 1;

  typedef enum logic {IDLE, DRAW} state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          seeded_q, seeded_d;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          eval;
  logic          accept;
  logic          push;
  logic          pop;
  logic          push_last;
  logic [7:0]    value;
  logic [5:0]    v6;

  // Only the low byte of the raw word is meaningful; wider words are tolerated.
  logic          unused_rnd;
  assign unused_rnd = ^rnd_i;

  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign eval       = (state_q == DRAW) && rnd_valid_i && !fifo_full;
  assign push       = eval && accept;
  assign pop        = !fifo_empty && bus.out_ready_i;
  assign push_last  = (rem_q == RW'(1));
  assign busy_o     = (state_q == DRAW);

`ifdef RANGE_REJECT_LIMIT_EN
  logic [3:0] rej_cnt_q, rej_cnt_d;

  // Consecutive mode-2 rejection counter; cleared on burst start and on every push.
  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (state_q == IDLE && bus.req_valid_i) begin
      rej_cnt_d = 4'd0;
    end else if (push) begin
      rej_cnt_d = 4'd0;
    end else if (eval) begin
      rej_cnt_d = rej_cnt_q + 4'd1;
    end
  end

  // Rejection counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_cnt_q <= 4'd0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
    end
  end
`endif

  // Map the current raw sample according to the burst mode and decide accept/reject.
  always_comb begin
    v6     = rnd_i[5:0];
    accept = 1'b0;
    value  = 8'd0;
    case (mode_q)
      2'd1: begin
        accept = 1'b1;
        value  = {6'd0, rnd_i[1:0]};
      end
      2'd2: begin
        if (v6 < 6'd40) begin
          accept = 1'b1;
          value  = {2'b00, v6} + 8'd1;
        end
`ifdef RANGE_REJECT_LIMIT_EN
        else if (rej_cnt_q == 4'hF) begin
          // Folds 40..63 onto 17..40 so a stuck source still makes progress.
          accept = 1'b1;
          value  = {2'b00, v6} - 8'd23;
        end
`endif
      end
      default: begin
        accept = 1'b1;
        value  = rnd_i[7:0];
      end
    endcase
  end

  // Burst FSM next state, request handshake and one-shot LFSR start.
  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    rem_d           = rem_q;
    seeded_d        = seeded_q;
    bus.req_ready_o = 1'b0;
    lfsr_start_o    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          mode_d       = bus.req_mode_i;
          rem_d        = {1'b0, bus.req_count_i} + RW'(1);
          state_d      = DRAW;
          lfsr_start_o = !seeded_q;
          seeded_d     = 1'b1;
        end
      end
      DRAW: begin
        if (push) begin
          rem_d = rem_q - RW'(1);
          if (push_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and burst bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 2'd0;
      rem_q    <= '0;
      seeded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rem_q    <= rem_d;
      seeded_q <= seeded_d;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage of {last, data}; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {push_last, value};
    end
  end

  assign bus.out_valid_o = !fifo_empty;
  assign bus.out_data_o  = fifo_empty ? 8'd0 : mem_q[rd_ptr_q][7:0];
  assign bus.out_last_o  = fifo_empty ? 1'b0 : mem_q[rd_ptr_q][8];

endmodule

// File: tb/tb_rand_range_sampler.sv
// tb/tb_rand_range_sampler.sv - directed self-checking bench for rand_range_sampler
module tb_rand_range_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rnd_i;
  logic       rnd_valid_i;
  logic       lfsr_start_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int n;
  int first;

  logic [7:0] exp3 [8] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd2, 8'd3, 8'd0, 8'd1};
  logic [7:0] tbl3 [5] = '{8'h0D, 8'h0E, 8'h33, 8'h10, 8'h25};
  logic [7:0] exp_d [$];
  logic       exp_l [$];

  rand_range_sampler_if #(.CNT_W(4)) bus ();

  rand_range_sampler #(
    .S_WIDTH   (8),
    .FIFO_DEPTH(4),
    .CNT_W     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rnd_i       (rnd_i),
    .rnd_valid_i (rnd_valid_i),
    .lfsr_start_o(lfsr_start_o),
    .busy_o      (busy_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 40 && exp_d.size() > 0; k++) begin
      if (bus.out_valid_o) begin
        chk8({tag, "_data"}, bus.out_data_o, exp_d.pop_front());
        chk1({tag, "_last"}, bus.out_last_o, exp_l.pop_front());
      end
      tick();
    end
    chk8({tag, "_left"}, 8'(exp_d.size()), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    rnd_i           = 8'h00;
    rnd_valid_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_mode_i  = 2'd0;
    bus.req_count_i = 4'd0;
    bus.out_ready_i = 1'b1;
    tick();
    tick();

    chk1("rst_start", lfsr_start_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_valid", bus.out_valid_o, 1'b0);
    chk8("rst_data", bus.out_data_o, 8'd0);
    chk1("rst_last", bus.out_last_o, 1'b0);
    chk1("rst_ready", bus.req_ready_o, 1'b1);
    rst_n = 1'b1;
    tick();

    // Seeding: first request pulses the LFSR start, later ones do not
    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = 2'd0;
    bus.req_count_i = 4'd0;
    #1;
    chk1("seed_pulse", lfsr_start_o, 1'b1);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    chk1("seed_pulse_once", lfsr_start_o, 1'b0);
    chk1("seed_busy", busy_o, 1'b1);
    chk1("seed_ready_low", bus.req_ready_o, 1'b0);
    rnd_i       = 8'hA5;
    rnd_valid_i = 1'b1;
    tick();
    rnd_valid_i = 1'b0;
    chk1("seed_valid", bus.out_valid_o, 1'b1);
    chk8("seed_data", bus.out_data_o, 8'hA5);
    chk1("seed_last", bus.out_last_o, 1'b1);
    chk1("seed_idle", busy_o, 1'b0);
    bus.req_valid_i = 1'b1;
    #1;
    chk1("seed_no_second", lfsr_start_o, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    chk1("seed_popped", bus.out_valid_o, 1'b0);
    rnd_i       = 8'h11;
    rnd_valid_i = 1'b1;
    tick();
    rnd_valid_i = 1'b0;
    chk8("seed2_data", bus.out_data_o, 8'h11);
    chk1("seed2_last", bus.out_last_o, 1'b1);
    tick();
    chk1("seed2_popped", bus.out_valid_o, 1'b0);

    // Mode 2 mapping with one rejection
    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = 2'd2;
    bus.req_count_i = 4'd2;
    tick();
    bus.req_valid_i = 1'b0;
    rnd_i       = 8'h2A;
    rnd_valid_i = 1'b1;
    tick();
    chk1("m2_reject", bus.out_valid_o, 1'b0);
    chk1("m2_busy", busy_o, 1'b1);
    rnd_i = 8'h27;
    tick();
    chk8("m2_v40", bus.out_data_o, 8'd40);
    chk1("m2_v40_last", bus.out_last_o, 1'b0);
    rnd_i = 8'h00;
    tick();
    chk8("m2_v1", bus.out_data_o, 8'd1);
    chk1("m2_v1_last", bus.out_last_o, 1'b0);
    rnd_i = 8'hC3;
    tick();
    chk8("m2_v4", bus.out_data_o, 8'd4);
    chk1("m2_v4_last", bus.out_last_o, 1'b1);
    chk1("m2_idle", busy_o, 1'b0);
    rnd_valid_i = 1'b0;
    tick();
    chk1("m2_empty", bus.out_valid_o, 1'b0);

    // Mode 1 with backpressure: four pushes fill the FIFO, then the draw stalls
    bus.out_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = 2'd1;
    bus.req_count_i = 4'd7;
    tick();
    bus.req_valid_i = 1'b0;
    rnd_valid_i     = 1'b1;
    rnd_i           = 8'hFF;
    tick();
    chk1("m1_first_valid", bus.out_valid_o, 1'b1);
    chk8("m1_first_data", bus.out_data_o, 8'd3);
    rnd_i = 8'h02;
    tick();
    rnd_i = 8'h81;
    tick();
    rnd_i = 8'h44;
    tick();
    rnd_i = 8'h07;
    tick();
    rnd_i = 8'h06;
    tick();
    chk1("m1_stall_busy", busy_o, 1'b1);
    chk1("m1_stall_ready", bus.req_ready_o, 1'b0);
    chk8("m1_stall_head", bus.out_data_o, 8'd3);
    chk1("m1_stall_last", bus.out_last_o, 1'b0);
    bus.out_ready_i = 1'b1;
    n = 0;
    for (int k = 0; k < 30 && n < 8; k++) begin
      rnd_i = (k < 5) ? tbl3[k] : 8'h00;
      if (bus.out_valid_o) begin
        chk8("m1_data", bus.out_data_o, exp3[n]);
        chk1("m1_last", bus.out_last_o, (n == 7));
        n++;
      end
      tick();
    end
    rnd_valid_i = 1'b0;
    chk8("m1_total", 8'(n), 8'd8);
    chk1("m1_idle", busy_o, 1'b0);
    chk1("m1_empty", bus.out_valid_o, 1'b0);

    // Overlap: second burst accepted while the first is still buffered
    bus.out_ready_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = 2'd0;
    bus.req_count_i = 4'd1;
    rnd_valid_i     = 1'b1;
    rnd_i           = 8'h10;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    rnd_i = 8'h20;
    tick();
    chk1("ov_idle", busy_o, 1'b0);
    chk1("ov_ready", bus.req_ready_o, 1'b1);
    chk8("ov_head1", bus.out_data_o, 8'h10);
    chk1("ov_head1_last", bus.out_last_o, 1'b0);
    bus.req_valid_i = 1'b1;
    rnd_i           = 8'h30;
    tick();
    bus.req_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    rnd_i           = 8'h40;
    chk8("ov_head2", bus.out_data_o, 8'h20);
    chk1("ov_head2_last", bus.out_last_o, 1'b1);
    tick();
    rnd_valid_i = 1'b0;
    chk1("ov_done", busy_o, 1'b0);
    exp_d = '{8'h20, 8'h30, 8'h40};
    exp_l = '{1'b1, 1'b0, 1'b1};
    drain("ov");
    chk1("ov_empty", bus.out_valid_o, 1'b0);

    // Held out-of-range sample in mode 2
    bus.out_ready_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = 2'd2;
    bus.req_count_i = 4'd0;
    rnd_i           = 8'h3F;
    rnd_valid_i     = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    first = 0;
    for (int k = 1; k <= 100 && first == 0; k++) begin
      tick();
      if (bus.out_valid_o) begin
        first = k;
        chk8("rej_data", bus.out_data_o, 8'd40);
        chk1("rej_last", bus.out_last_o, 1'b1);
      end
    end
`ifdef RANGE_REJECT_LIMIT_EN
    chk8("rej_latency", 8'(first), 8'd16);
`else
    chk8("rej_unbounded", 8'(first), 8'd0);
    chk1("rej_still_busy", busy_o, 1'b1);
`endif
    rnd_valid_i = 1'b0;

    // Reset mid-burst with three buffered entries
    rst_n = 1'b0;
    #1;
    chk1("rr0_busy", busy_o, 1'b0);
    tick();
    rst_n           = 1'b1;
    bus.out_ready_i = 1'b0;
    tick();
    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = 2'd0;
    bus.req_count_i = 4'd7;
    #1;
    chk1("rr_seed_pulse", lfsr_start_o, 1'b1);
    tick();
    bus.req_valid_i = 1'b0;
    rnd_valid_i     = 1'b1;
    rnd_i           = 8'h01;
    tick();
    rnd_i = 8'h02;
    tick();
    rnd_i = 8'h03;
    tick();
    rnd_valid_i = 1'b0;
    chk1("rr_pre_busy", busy_o, 1'b1);
    chk8("rr_pre_head", bus.out_data_o, 8'h01);
    rst_n = 1'b0;
    #1;
    chk1("rr_valid", bus.out_valid_o, 1'b0);
    chk1("rr_ready", bus.req_ready_o, 1'b1);
    chk1("rr_busy", busy_o, 1'b0);
    chk8("rr_data", bus.out_data_o, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.req_valid_i = 1'b1;
    bus.req_mode_i  = 2'd3;
    bus.req_count_i = 4'd0;
    #1;
    chk1("rr_reseed_pulse", lfsr_start_o, 1'b1);
    tick();
    bus.req_valid_i = 1'b0;
    rnd_i           = 8'hC7;
    rnd_valid_i     = 1'b1;
    tick();
    rnd_valid_i = 1'b0;
    chk8("m3_data", bus.out_data_o, 8'hC7);
    chk1("m3_last", bus.out_last_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_range_sampler.md
# rand_range_sampler

Consumes the raw 8-bit pseudo-random stream produced by the LFSR stage and turns it into bounded random values on request: 0–255, 0–3, or 1–40. It sits directly downstream of the LFSR. It issues the LFSR's one-shot start pulse, draws one raw sample per cycle, and maps or rejects each sample according to the request mode. Accepted values are buffered in a small FIFO and delivered over a valid/ready stream with a last-of-burst tag.

## Interface
- S_WIDTH, 8, raw random word width; must be ≥ 8; only bits [7:0] are used.
- FIFO_DEPTH, 4, output buffer entries; must be a power of 2, ≥ 2.
- CNT_W, 4, width of the burst-count field.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rnd_i  in  S_WIDTH  raw LFSR word; a new value every cycle.
- rnd_valid_i  in  1  rnd_i is live (the LFSR has been started).
- lfsr_start_o  out  1  one-cycle pulse that starts the LFSR; connects to the LFSR's in_valid.
- req_valid_i  in  1  burst request.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_mode_i  in  2  0: 0–255, 1: 0–3, 2: 1–40, 3: reserved (treated as 0).
- req_count_i  in  CNT_W  number of values in the burst = req_count_i + 1.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accepts the head.
- out_data_o  out  8  mapped value.
- out_last_o  out  1  head is the final value of its burst.
- busy_o  out  1  FSM is in DRAW.

## Operation
- **FSM IDLE**
  - req_ready_o = 1.
  - On handshake: latch mode and remaining = req_count_i + 1, then go to DRAW.
- **FSM DRAW**
  - req_ready_o = 0.
  - A sample is evaluated in a cycle only when rnd_valid_i = 1 and the FIFO is not full at the start of that cycle.
  - Each accepted sample is pushed and decrements remaining.
  - When the push carries remaining = 1, the entry is tagged last and the FSM returns to IDLE.
- **Mapping**
  - Mode 0/3: value = rnd_i[7:0]; always accepted.
  - Mode 1: value = rnd_i[1:0], zero-extended; always accepted.
  - Mode 2: v = rnd_i[5:0]. If v < 40, accept value = v + 1. If v ≥ 40, reject: no push, remaining unchanged.
- **lfsr_start_o**
  - A sticky `seeded` flag is cleared by reset.
  - lfsr_start_o = 1 for exactly the one cycle in which the first request is accepted after reset; `seeded` then sets.
  - Later requests never pulse it.
- **FIFO**
  - 9 bits wide: {last, data}.
  - Pop when out_valid_o && out_ready_i.
  - Push and pop may occur in the same cycle.
  - No bypass: a pushed value is visible no earlier than the next cycle.
- **Output independence:** the output drains regardless of FSM state. A new request may be accepted while earlier values remain in the FIFO.

## Timing
- Reset values:
  - lfsr_start_o = 0, busy_o = 0, out_valid_o = 0, out_data_o = 0, out_last_o = 0.
  - req_ready_o = 1; FSM in IDLE; FIFO empty; `seeded` = 0.
  - Reject counter = 0.
- Request handshake at cycle T: busy_o = 1 from T+1. The first evaluation happens at T+1 if rnd_valid_i is high.
- Sample accepted at cycle E: out_valid_o = 1 at E+1 if the FIFO was empty.
- Best-case burst of N values: N consecutive push cycles; IDLE and req_ready_o = 1 in the cycle after the last push.
- FIFO full with out_ready_i = 0: DRAW stalls and raw samples are discarded. When a pop occurs at cycle P, evaluation resumes at P+1.
- Full and pop in the same cycle: no push that cycle.
- rnd_valid_i low during DRAW: stall; no state change.
- rst_n asserted mid-burst: immediate return to reset values; FIFO contents are lost.

## Configuration
- RANGE_REJECT_LIMIT_EN
  - Defined: a 4-bit counter counts consecutive mode-2 rejections. It clears on any accept and on entry to DRAW. On the 16th consecutive rejection the sample is force-accepted with value = v − 23 (range 17–40) and the counter clears. Worst-case draw latency per value is therefore 16 valid cycles.
  - Undefined: the counter is not built; rejection is unbounded.

## Test plan
- **Seeding:** reset, then a request with mode 0, count 0 → lfsr_start_o high for exactly 1 cycle. Drive rnd_i = 0xA5 → out_data_o = 0xA5, out_last_o = 1. A second request produces no start pulse.
- **Mode 2 mapping:** count 2; rnd_i = 0x2A, 0x27, 0x00, 0xC3 → outputs 40, 1, 4. 0x2A (42) is rejected and produces no push; 0x27 gives 40, 0x00 gives 1, 0xC3 (low 6 bits = 3) gives 4. out_last_o set only on 4.
- **Mode 1 / backpressure:** count 7, FIFO_DEPTH 4, out_ready_i = 0 → exactly 4 pushes, then busy_o stays 1 and the stall holds. Release out_ready_i → 8 values total, each ≤ 3, last tagged.
- **Overlap:** burst 1 (count 1) drains slowly while burst 2 is accepted → values delivered in order and out_last_o set on entries 2 and 4 only.
- **Reject limit (macro defined):** mode 2, rnd_i = 0x3F held for 16 cycles → one output of 40 on the 16th cycle. With the macro undefined → no output after 100 cycles.
- **Reset mid-burst:** assert rst_n low during DRAW with 3 FIFO entries → next cycle out_valid_o = 0, req_ready_o = 1, busy_o = 0. The next request pulses lfsr_start_o again.
